// File: rtl/hex_loader_pkg.sv
// Shared types and ASCII constants for the hex stream loaders.
package hex_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WRITE
    } state_t;

    typedef enum logic [2:0] {
        CC_HEX,
        CC_EOL,
        CC_RESTART,
        CC_SEP,
        CC_BAD
    } char_class_t;

    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_AT     = 8'h40;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_USCORE = 8'h5F;

endpackage

// File: rtl/hex_char_classify.sv
// Combinational byte classifier: character class plus hex nibble value.
// No latency, no flow control; nibble is 0 for non-hex bytes.
module hex_char_classify
    import hex_loader_pkg::*;
(
    input  logic [7:0]  ch_i,
    output char_class_t cls_o,
    output logic [3:0]  nib_o
);

    always_comb begin
        cls_o = CC_BAD;
        nib_o = 4'h0;
        if (ch_i >= 8'h30 && ch_i <= 8'h39) begin
            cls_o = CC_HEX;
            nib_o = ch_i[3:0];
        end else if ((ch_i >= 8'h41 && ch_i <= 8'h46) ||
                     (ch_i >= 8'h61 && ch_i <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
            cls_o = CC_HEX;
            nib_o = ch_i[3:0] + 4'd9;
        end else if (ch_i == ASCII_LF || ch_i == ASCII_CR) begin
            cls_o = CC_EOL;
        end else if (ch_i == ASCII_AT) begin
            cls_o = CC_RESTART;
        end else if (ch_i == ASCII_SPACE || ch_i == ASCII_COMMA ||
                     ch_i == ASCII_USCORE) begin
            cls_o = CC_SEP;
        end
    end

endmodule

// File: rtl/hex_word_loader.sv
// ASCII hex stream -> sequential WORD_W-bit memory writes; 2 cycles/byte, 3 on word completion.
// Bytes are taken only in IDLE (and, with HEX_LOADER_ECHO_EN, only while tx_busy is low).
module hex_word_loader
    import hex_loader_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_clr,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err,
    output logic [3:0]        nib_disp
);

    localparam int NPW   = WORD_W / 4;
    localparam int NIB_W = $clog2(NPW) + 1;

    state_t              state_q;
    logic [7:0]          byte_q;
    logic [WORD_W-1:0]   acc_q;
    logic [NIB_W-1:0]    nib_cnt_q;
    logic [3:0]          nib_disp_q;
    logic                err_q;
    logic                rx_clr_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [ADDR_W:0]     word_count_q;

    char_class_t         cls;
    logic [3:0]          nib;
    logic [WORD_W-1:0]   acc_d;
    logic [NIB_W-1:0]    nib_cnt_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                last_nib;
    logic                accept;

    hex_char_classify u_classify (
        .ch_i  (byte_q),
        .cls_o (cls),
        .nib_o (nib)
    );

    assign acc_d      = (acc_q << 4) | WORD_W'(nib);
    assign nib_cnt_d  = nib_cnt_q + NIB_W'(1);
    assign last_nib   = (nib_cnt_q == NIB_W'(NPW - 1));
    assign mem_addr_d = (mem_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : mem_addr_q + ADDR_W'(1);

`ifdef HEX_LOADER_ECHO_EN
    logic [7:0] tx_data_q;
    logic       tx_wr_q;

    assign accept = rx_rdy && !tx_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            tx_wr_q <= 1'b0;
            if (state_q == ST_DECODE) begin
                tx_wr_q   <= 1'b1;
                tx_data_q <= byte_q;
            end
        end
    end

    assign tx_wr   = tx_wr_q;
    assign tx_data = tx_data_q;
`else
    logic unused_tx_busy;

    assign unused_tx_busy = tx_busy;
    assign accept         = rx_rdy;
    assign tx_wr          = 1'b0;
    assign tx_data        = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            byte_q       <= 8'h00;
            acc_q        <= '0;
            nib_cnt_q    <= '0;
            nib_disp_q   <= 4'h0;
            err_q        <= 1'b0;
            rx_clr_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            word_count_q <= '0;
        end else begin
            rx_clr_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        byte_q   <= rx_data;
                        rx_clr_q <= 1'b1;
                        state_q  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_q <= ST_IDLE;
                    case (cls)
                        CC_HEX: begin
                            acc_q      <= acc_d;
                            nib_disp_q <= nib;
                            nib_cnt_q  <= nib_cnt_d;
                            if (last_nib) begin
                                // strobe is suppressed here when full; WRITE flags the overflow
                                state_q  <= ST_WRITE;
                                mem_we_q <= !full;
                            end
                        end
                        CC_EOL: begin
                            if (nib_cnt_q != '0) begin
                                err_q <= 1'b1;
                            end
                            nib_cnt_q <= '0;
                        end
                        CC_RESTART: begin
                            mem_addr_q   <= '0;
                            word_count_q <= '0;
                            nib_cnt_q    <= '0;
                            err_q        <= 1'b0;
                        end
                        CC_SEP: begin
                        end
                        default: begin
                            err_q <= 1'b1;
                        end
                    endcase
                end
                ST_WRITE: begin
                    state_q   <= ST_IDLE;
                    nib_cnt_q <= '0;
                    if (mem_we_q) begin
                        mem_addr_q   <= mem_addr_d;
                        word_count_q <= word_count_q + (ADDR_W+1)'(1);
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_clr     = rx_clr_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = acc_q;
    assign word_count = word_count_q;
    assign full       = (word_count_q == (ADDR_W+1)'(DEPTH));
    assign err        = err_q;
    assign nib_disp   = nib_disp_q;

endmodule

// File: tb/tb_hex_word_loader.sv
// Directed bench for hex_word_loader with a 4-entry, 32-bit memory.
module tb_hex_word_loader;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              rx_clr;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              full;
    logic              err;
    logic [3:0]        nib_disp;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] we_addr[$];
    logic [WORD_W-1:0] we_data[$];
    logic [7:0]        tx_q[$];

    always #5 clk = ~clk;

    hex_word_loader #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_clr     (rx_clr),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .full       (full),
        .err        (err),
        .nib_disp   (nib_disp)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                we_addr.push_back(mem_addr);
                we_data.push_back(mem_wdata);
            end
            if (tx_wr) tx_q.push_back(tx_data);
        end
    end

    task automatic clear_cap();
        we_addr.delete();
        we_data.delete();
        tx_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rx_clr) got = 1'b1;
        end
        rx_rdy = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_byte_timeout byte=%h: rx_clr not seen within 20 cycles", b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);
        checks++; if (mem_we !== 1'b0)        begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== '0)        begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0)       begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (word_count !== '0)      begin errors++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
        checks++; if (full !== 1'b0)          begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (err !== 1'b0)           begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (nib_disp !== 4'h0)      begin errors++; $display("FAIL reset_nib_disp got=%h exp=0", nib_disp); end
        checks++; if (rx_clr !== 1'b0)        begin errors++; $display("FAIL reset_rx_clr got=%b exp=0", rx_clr); end
        checks++; if ({tx_wr, tx_data} !== 9'h0) begin errors++; $display("FAIL reset_tx got=%b/%h exp=0/00", tx_wr, tx_data); end
    endtask

    task automatic test_single_word();
        string exp_s = "12345678";
        clear_cap();
        send_str("1234567");
        @(negedge clk);
        rx_data = "8";
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0;
        checks++; if (rx_clr !== 1'b1) begin errors++; $display("FAIL t1_rx_clr got=%b exp=1", rx_clr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL t1_mem_we_early got=%b exp=0", mem_we); end
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL t2_mem_we got=%b exp=1", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL t2_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL t2_mem_wdata got=%h exp=12345678", mem_wdata); end
        checks++; if (word_count !== 3'd0) begin errors++; $display("FAIL t2_word_count got=%0d exp=0", word_count); end
`ifdef HEX_LOADER_ECHO_EN
        checks++; if ({tx_wr, tx_data} !== {1'b1, 8'h38}) begin errors++; $display("FAIL t2_echo got=%b/%h exp=1/38", tx_wr, tx_data); end
`endif
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL t3_mem_we got=%b exp=0", mem_we); end
        checks++; if (word_count !== 3'd1) begin errors++; $display("FAIL t3_word_count got=%0d exp=1", word_count); end
        checks++; if (mem_addr !== 2'd1) begin errors++; $display("FAIL t3_mem_addr got=%h exp=1", mem_addr); end
        idle(2);
        checks++; if (we_data.size() !== 1) begin errors++; $display("FAIL single_we_count got=%0d exp=1", we_data.size()); end
        checks++; if (nib_disp !== 4'h8) begin errors++; $display("FAIL single_nib_disp got=%h exp=8", nib_disp); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", err); end
`ifdef HEX_LOADER_ECHO_EN
        checks++; if (tx_q.size() !== 8) begin errors++; $display("FAIL echo_count got=%0d exp=8", tx_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_q.size() <= i || tx_q[i] !== exp_s[i]) begin
                errors++;
                $display("FAIL echo_byte idx=%0d got=%h exp=%h", i, (tx_q.size() > i) ? tx_q[i] : 8'hxx, exp_s[i]);
            end
        end
`else
        checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL echo_disabled got=%0d writes exp=0 (%s)", tx_q.size(), exp_s); end
`endif
    endtask

    task automatic test_two_words();
        send_byte("@");
        clear_cap();
        send_str("dead beef\n");
        send_str("CAFE_F00D");
        idle(3);
        checks++; if (we_data.size() !== 2) begin errors++; $display("FAIL two_we_count got=%0d exp=2", we_data.size()); end
        checks++; if (we_addr[0] !== 2'd0 || we_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL two_word0 got=%h:%h exp=0:deadbeef", we_addr[0], we_data[0]); end
        checks++; if (we_addr[1] !== 2'd1 || we_data[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL two_word1 got=%h:%h exp=1:cafef00d", we_addr[1], we_data[1]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL two_err got=%b exp=0", err); end
        checks++; if (word_count !== 3'd2) begin errors++; $display("FAIL two_word_count got=%0d exp=2", word_count); end
        checks++; if (nib_disp !== 4'hD) begin errors++; $display("FAIL two_nib_disp got=%h exp=d", nib_disp); end
    endtask

    task automatic test_bad_char();
        send_byte("@");
        clear_cap();
        send_str("12G");
        idle(1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err_after_G got=%b exp=1", err); end
        checks++; if (nib_disp !== 4'h2) begin errors++; $display("FAIL bad_nib_disp_G got=%h exp=2", nib_disp); end
        send_str("4\n");
        idle(2);
        checks++; if (we_data.size() !== 0) begin errors++; $display("FAIL bad_no_write got=%0d exp=0", we_data.size()); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err_after_eol got=%b exp=1", err); end
        checks++; if (word_count !== 3'd0) begin errors++; $display("FAIL bad_word_count got=%0d exp=0", word_count); end
        checks++; if (nib_disp !== 4'h4) begin errors++; $display("FAIL bad_nib_disp got=%h exp=4", nib_disp); end
        send_str("ABCDEF01");
        idle(3);
        checks++; if (we_data.size() !== 1 || we_data[0] !== 32'hABCDEF01 || we_addr[0] !== 2'd0) begin
            errors++; $display("FAIL bad_resync_word got=%0d writes first=%h:%h exp=1 0:abcdef01", we_data.size(), we_addr[0], we_data[0]);
        end
    endtask

    task automatic test_overflow();
        string       ws[5] = '{"01234567", "89abcdef", "FEDCBA98", "76543210", "11223344"};
        logic [31:0] wv[5] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 32'h11223344};
        send_byte("@");
        idle(1);
        checks++; if (err !== 1'b0 || word_count !== 3'd0) begin errors++; $display("FAIL ovf_restart got err=%b cnt=%0d exp 0/0", err, word_count); end
        clear_cap();
        for (int i = 0; i < 4; i++) send_str(ws[i]);
        idle(2);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_at_full got=%b exp=0", err); end
        checks++; if (word_count !== 3'd4) begin errors++; $display("FAIL ovf_count_at_full got=%0d exp=4", word_count); end
        send_str(ws[4]);
        idle(3);
        checks++; if (we_data.size() !== 4) begin errors++; $display("FAIL ovf_we_count got=%0d exp=4", we_data.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (we_addr[i] !== ADDR_W'(i) || we_data[i] !== wv[i]) begin
                errors++; $display("FAIL ovf_word idx=%0d got=%h:%h exp=%h:%h", i, we_addr[i], we_data[i], ADDR_W'(i), wv[i]);
            end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b exp=1", err); end
        checks++; if (word_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", word_count); end
        send_byte("@");
        idle(1);
        checks++; if (word_count !== 3'd0 || full !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL ovf_clear got cnt=%0d full=%b err=%b exp 0/0/0", word_count, full, err);
        end
        clear_cap();
        send_str("55667788");
        idle(3);
        checks++; if (we_data.size() !== 1 || we_addr[0] !== 2'd0 || we_data[0] !== 32'h55667788) begin
            errors++; $display("FAIL ovf_after_restart got=%0d writes first=%h:%h exp=1 0:55667788", we_data.size(), we_addr[0], we_data[0]);
        end
    endtask

    task automatic test_tx_busy();
        send_byte("@");
        @(negedge clk);
        tx_busy = 1'b1;
        rx_data = "5";
        rx_rdy  = 1'b1;
`ifdef HEX_LOADER_ECHO_EN
        begin
            int seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (rx_clr) seen++;
            end
            checks++; if (seen !== 0) begin errors++; $display("FAIL busy_no_accept got=%0d rx_clr pulses exp=0", seen); end
        end
        tx_busy = 1'b0;
        @(negedge clk);
        checks++; if (rx_clr !== 1'b1) begin errors++; $display("FAIL busy_release_accept got rx_clr=%b exp=1", rx_clr); end
`else
        @(negedge clk);
        checks++; if (rx_clr !== 1'b1) begin errors++; $display("FAIL busy_ignored_accept got rx_clr=%b exp=1", rx_clr); end
        tx_busy = 1'b0;
`endif
        rx_rdy = 1'b0;
        idle(2);
        checks++; if (nib_disp !== 4'h5) begin errors++; $display("FAIL busy_nib_disp got=%h exp=5", nib_disp); end
    endtask

    task automatic test_reset_mid();
        send_byte("@");
        send_str("12345");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || word_count !== '0 ||
                      err !== 1'b0 || nib_disp !== 4'h0 || rx_clr !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got we=%b addr=%h wdata=%h cnt=%0d err=%b nib=%h exp all 0",
                               mem_we, mem_addr, mem_wdata, word_count, err, nib_disp);
        end
        rst = 1'b0;
        clear_cap();
        send_str("9ABCDEF0");
        idle(3);
        checks++; if (we_data.size() !== 1 || we_addr[0] !== 2'd0 || we_data[0] !== 32'h9ABCDEF0) begin
            errors++; $display("FAIL midrst_fresh_word got=%0d writes first=%h:%h exp=1 0:9abcdef0", we_data.size(), we_addr[0], we_data[0]);
        end
        checks++; if (word_count !== 3'd1) begin errors++; $display("FAIL midrst_count got=%0d exp=1", word_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_bad_char();
        test_overflow();
        test_tx_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
